cp0_regfile: RTL

Coprocessor-0 register file for the MIPS pipeline. It sits directly downstream of the memory-stage exception-priority unit. It consumes that unit's encoded exception type, together with the faulting PC, delay-slot flag and bad address, and commits the architectural side effects: EPC, Cause, Status.EXL and BadVAddr. It also services `mtc0`/`mfc0`, runs the Count/Compare timer, and feeds `status_o`, `cause_o` and `epc_o` back to the exception-priority unit.

---
 rtl/cp0_regfile_pkg.sv | 61 ++++++
 rtl/cp0_regfile_timer.sv | 47 ++++
 rtl/cp0_regfile.sv | 129 ++++++++++++
 3 files changed

// File: rtl/cp0_regfile_pkg.sv
// cp0_regfile_pkg: constants shared by the CP0 register file and the
// memory-stage exception-priority unit.
//   - EXC_TYPE_*   : encodings of the excepttype bus from the priority unit
//   - CP0_REG_*    : CP0 register numbers used by mtc0/mfc0
//   - Status/Cause : bit positions and software-writable masks
//   - exc_code()   : maps an exception type onto its Cause.ExcCode value
package cp0_regfile_pkg;

    localparam logic [31:0] EXC_TYPE_NOEXC       = 32'h0000_0000;
    localparam logic [31:0] EXC_TYPE_INT         = 32'h0000_0001;
    localparam logic [31:0] EXC_TYPE_ADEL        = 32'h0000_0004;
    localparam logic [31:0] EXC_TYPE_ADES        = 32'h0000_0005;
    localparam logic [31:0] EXC_TYPE_SYS         = 32'h0000_0008;
    localparam logic [31:0] EXC_TYPE_BP          = 32'h0000_0009;
    localparam logic [31:0] EXC_TYPE_RI          = 32'h0000_000a;
    localparam logic [31:0] EXC_TYPE_OV          = 32'h0000_000c;
    localparam logic [31:0] EXC_TYPE_ERET        = 32'h0000_000e;
    localparam logic [31:0] EXC_TYPE_INT_FORWARD = 32'h0000_000f;

    localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
    localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_REG_EPC      = 5'd14;
    localparam logic [4:0] CP0_REG_PRID     = 5'd15;
    localparam logic [4:0] CP0_REG_CONFIG   = 5'd16;

    localparam int STATUS_EXL_BIT = 1;
    localparam int CAUSE_BD_BIT   = 31;
    localparam int CAUSE_TI_BIT   = 30;

    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;  // BEV=1
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;  // IM, EXL, IE
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;  // software IP[1:0]

    typedef enum logic [4:0] {
        EXC_CODE_INT  = 5'd0,
        EXC_CODE_ADEL = 5'd4,
        EXC_CODE_ADES = 5'd5,
        EXC_CODE_SYS  = 5'd8,
        EXC_CODE_BP   = 5'd9,
        EXC_CODE_RI   = 5'd10,
        EXC_CODE_OV   = 5'd12
    } exc_code_e;

    function automatic exc_code_e exc_code(input logic [31:0] exc_type);
        exc_code_e code;
        case (exc_type)
            EXC_TYPE_ADEL: code = EXC_CODE_ADEL;
            EXC_TYPE_ADES: code = EXC_CODE_ADES;
            EXC_TYPE_SYS:  code = EXC_CODE_SYS;
            EXC_TYPE_BP:   code = EXC_CODE_BP;
            EXC_TYPE_RI:   code = EXC_CODE_RI;
            EXC_TYPE_OV:   code = EXC_CODE_OV;
            default:       code = EXC_CODE_INT;  // INT, INT_FORWARD
        endcase
        return code;
    endfunction

endpackage

// File: rtl/cp0_regfile_timer.sv
// cp0_timer: Count/Compare timer of CP0.
//   clk, rst       : clock, asynchronous active-low reset
//   count_we       : load Count from data (overrides the increment)
//   compare_we     : load Compare from data and clear the timer interrupt
//   data           : write data
//   count/compare  : registered Count and Compare
//   timer_int      : sticky timer interrupt, cleared only by a Compare write
module cp0_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] data,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_int
);

    // Count advances on the cycles where the phase flop is 1, i.e. at half rate.
    logic tick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick      <= 1'b0;
            count     <= 32'd0;
            compare   <= 32'd0;
            timer_int <= 1'b0;
        end else begin
            tick <= ~tick;

            if (count_we) begin
                count <= data;
            end else if (tick) begin
                count <= count + 32'd1;
            end

            // Clear beats a simultaneous match.
            if (compare_we) begin
                compare   <= data;
                timer_int <= 1'b0;
            end else if ((compare != 32'd0) && (count == compare)) begin
                timer_int <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_regfile.sv
// cp0_regfile: Coprocessor-0 register file.
// Commits exception side effects (EPC, Cause, Status.EXL, BadVAddr) from the
// exception-priority unit, services mtc0/mfc0 and hosts the Count/Compare timer.
//   clk, rst                  : clock, asynchronous active-low reset
//   we_i, waddr_i, data_i     : mtc0 write port
//   raddr_i, data_o           : mfc0 read port (combinational)
//   int_i                     : level-sensitive hardware interrupts
//   excepttype_i              : encoded exception from the priority unit
//   current_inst_addr_i       : PC of the M-stage instruction
//   is_in_delayslot_i         : M-stage instruction sits in a delay slot
//   bad_addr_i                : faulting virtual address
//   count_o .. badvaddr_o     : registered CP0 registers
//   timer_int_o               : timer interrupt pending
module cp0_regfile
    import cp0_regfile_pkg::*;
#(
    parameter logic [31:0] PRID_VAL   = 32'h0001_8000,
    parameter logic [31:0] CONFIG_VAL = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [4:0]  raddr_i,
    input  logic [31:0] data_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] bad_addr_i,
    output logic [31:0] data_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] badvaddr_o,
    output logic        timer_int_o
);

    logic [31:0] status_q;
    logic [31:0] cause_q;
    logic [31:0] epc_q;
    logic [31:0] badvaddr_q;

    // Any exception (ERET included) flushes the mtc0 in the same slot.
    logic exc_active;
    logic is_eret;
    logic exc_commit;
    logic wr;
    logic addr_exc;

    assign exc_active = (excepttype_i != EXC_TYPE_NOEXC);
    assign is_eret    = (excepttype_i == EXC_TYPE_ERET);
    assign exc_commit = exc_active && !is_eret;
    assign wr         = we_i && !exc_active;
    assign addr_exc   = (excepttype_i == EXC_TYPE_ADEL) || (excepttype_i == EXC_TYPE_ADES);

    cp0_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (wr && (waddr_i == CP0_REG_COUNT)),
        .compare_we (wr && (waddr_i == CP0_REG_COMPARE)),
        .data       (data_i),
        .count      (count_o),
        .compare    (compare_o),
        .timer_int  (timer_int_o)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_q   <= STATUS_RESET;
            cause_q    <= 32'd0;
            epc_q      <= 32'd0;
            badvaddr_q <= 32'd0;
        end else begin
            // Hardware IP and TI are refreshed every cycle; they never overlap
            // the fields touched by exceptions or software writes.
            cause_q[15:10]       <= {int_i[5] | timer_int_o, int_i[4:0]};
            cause_q[CAUSE_TI_BIT] <= timer_int_o;

            if (wr) begin
                case (waddr_i)
                    CP0_REG_STATUS: status_q <= (status_q & ~STATUS_WMASK) | (data_i & STATUS_WMASK);
                    CP0_REG_CAUSE:  cause_q[9:8] <= data_i[9:8];
                    CP0_REG_EPC:    epc_q <= data_i;
                    default: ;
                endcase
            end

            if (exc_commit) begin
                // A nested exception keeps the EPC/BD of the outer one.
                if (!status_q[STATUS_EXL_BIT]) begin
                    epc_q                 <= is_in_delayslot_i ? (current_inst_addr_i - 32'd4)
                                                               : current_inst_addr_i;
                    cause_q[CAUSE_BD_BIT] <= is_in_delayslot_i;
                end
                status_q[STATUS_EXL_BIT] <= 1'b1;
                cause_q[6:2]             <= exc_code(excepttype_i);
                if (addr_exc) begin
                    badvaddr_q <= bad_addr_i;
                end
            end else if (is_eret) begin
                status_q[STATUS_EXL_BIT] <= 1'b0;
            end
        end
    end

    assign status_o   = status_q;
    assign cause_o    = cause_q;
    assign epc_o      = epc_q;
    assign badvaddr_o = badvaddr_q;

    always_comb begin
        data_o = 32'd0;
        case (raddr_i)
            CP0_REG_BADVADDR: data_o = badvaddr_q;
            CP0_REG_COUNT:    data_o = count_o;
            CP0_REG_COMPARE:  data_o = compare_o;
            CP0_REG_STATUS:   data_o = status_q;
            CP0_REG_CAUSE:    data_o = cause_q;
            CP0_REG_EPC:      data_o = epc_q;
            CP0_REG_PRID:     data_o = PRID_VAL;
            CP0_REG_CONFIG:   data_o = CONFIG_VAL;
            default:          data_o = 32'd0;
        endcase
    end

endmodule
